// File: rtl/cpe_pkg.sv
// CPE CPU shared definitions: datapath width, reset vector,
// base opcodes and the fetch state encoding.
package cpe_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic {
        FETCH,
        WAIT
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction queue of {pc, instr} between fetch and decode.
// Synchronous flush; head is read straight from registered storage.
module fetch_fifo #(
    parameter  int unsigned XLEN  = 32,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            push,
    input  logic [XLEN-1:0] push_pc,
    input  logic [31:0]     push_instr,
    input  logic            pop,
    output logic [CW-1:0]   count,
    output logic            head_valid,
    output logic [XLEN-1:0] head_pc,
    output logic [31:0]     head_instr
);

    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [31:0]     instr_q [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count_q;
    logic            do_push;
    logic            do_pop;

    assign do_push = push && (count_q != CW'(DEPTH));
    assign do_pop  = pop && (count_q != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                pc_q[wr_ptr]    <= push_pc;
                instr_q[wr_ptr] <= push_instr;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign count      = count_q;
    assign head_valid = (count_q != '0);
    assign head_pc    = pc_q[rd_ptr];
    assign head_instr = instr_q[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// CPE instruction fetch: one outstanding imem request, PC tracking,
// redirect flush with in-flight response discard, queue toward decode.
import cpe_pkg::*;

module fetch_unit #(
    parameter int unsigned     XLEN     = cpe_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = cpe_pkg::RESET_PC,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk_w_i,
    input  logic            rst_w_i_l,
    output logic            imem_req_w_o_h,
    output logic [XLEN-1:0] imem_addr_w_o,
    input  logic            imem_gnt_w_i_h,
    input  logic            imem_rvalid_w_i_h,
    input  logic [31:0]     imem_rdata_w_i,
    input  logic            redirect_w_i_h,
    input  logic [XLEN-1:0] redirect_pc_w_i,
    output logic            if_valid_w_o_h,
    input  logic            if_ready_w_i_h,
    output logic [31:0]     instr_w_o,
    output logic [XLEN-1:0] pc_w_o,
    output logic [6:0]      opcode_w_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] issue_pc_q, issue_pc_d;
    logic            discard_q, discard_d;
    logic [CW-1:0]   count;
    logic            fire;
    logic            push;
    logic            flush;

    assign imem_req_w_o_h = rst_w_i_l && (state_q == FETCH)
                            && (count < CW'(DEPTH));
    assign imem_addr_w_o  = fetch_pc_q;
    assign fire           = imem_req_w_o_h && imem_gnt_w_i_h;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        issue_pc_d = issue_pc_q;
        discard_d  = discard_q;
        push       = 1'b0;
        flush      = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (fire) begin
                    state_d    = WAIT;
                    fetch_pc_d = fetch_pc_q + XLEN'(4);
                    issue_pc_d = fetch_pc_q;
                end
            end
            WAIT: begin
                if (imem_rvalid_w_i_h) begin
                    push      = !discard_q;
                    discard_d = 1'b0;
                    state_d   = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
        // Redirect overrides the PC and the push, but not the handshake state.
        if (redirect_w_i_h) begin
            fetch_pc_d = redirect_pc_w_i & ~XLEN'(3);
            flush      = 1'b1;
            push       = 1'b0;
            if (fire || (state_q == WAIT && !imem_rvalid_w_i_h)) begin
                discard_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_w_i) begin
        if (!rst_w_i_l) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            issue_pc_q <= RESET_PC;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            issue_pc_q <= issue_pc_d;
            discard_q  <= discard_d;
        end
    end

    fetch_fifo #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk_w_i),
        .rst_n      (rst_w_i_l),
        .flush      (flush),
        .push       (push),
        .push_pc    (issue_pc_q),
        .push_instr (imem_rdata_w_i),
        .pop        (if_valid_w_o_h && if_ready_w_i_h),
        .count      (count),
        .head_valid (if_valid_w_o_h),
        .head_pc    (pc_w_o),
        .head_instr (instr_w_o)
    );

    assign opcode_w_o = instr_w_o[6:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table for streaming
// and back-pressure, hand sequences for grant stall, redirect and reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] redir_pc;
    logic        valid;
    logic        ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [6:0]  opcode;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk_w_i           (clk),
        .rst_w_i_l         (rst_l),
        .imem_req_w_o_h    (req),
        .imem_addr_w_o     (addr),
        .imem_gnt_w_i_h    (gnt),
        .imem_rvalid_w_i_h (rvalid),
        .imem_rdata_w_i    (rdata),
        .redirect_w_i_h    (redir),
        .redirect_pc_w_i   (redir_pc),
        .if_valid_w_o_h    (valid),
        .if_ready_w_i_h    (ready),
        .instr_w_o         (instr),
        .pc_w_o            (pc),
        .opcode_w_o        (opcode)
    );

    typedef struct {
        logic        rst;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic        hd;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(
        logic rst, logic g, logic rv, logic [31:0] rd, logic rdy,
        logic e_req, logic [31:0] e_addr, logic e_valid, logic hd,
        logic [31:0] e_pc, logic [31:0] e_instr);
        vec_t r;
        r.rst = rst; r.gnt = g; r.rv = rv; r.rdata = rd; r.rdy = rdy;
        r.e_req = e_req; r.e_addr = e_addr; r.e_valid = e_valid;
        r.hd = hd; r.e_pc = e_pc; r.e_instr = e_instr;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic g, input logic rv,
                        input logic [31:0] rd, input logic rdr,
                        input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        rst_l = r; gnt = g; rvalid = rv; rdata = rd;
        redir = rdr; redir_pc = rpc; ready = rdy;
        #1;
    endtask

    task automatic expect_out(input string tag, input logic e_req,
                              input logic [31:0] e_addr, input logic e_valid);
        chk({tag, ".req"}, 32'(req), 32'(e_req));
        chk({tag, ".addr"}, addr, e_addr);
        chk({tag, ".valid"}, 32'(valid), 32'(e_valid));
    endtask

    task automatic expect_head(input string tag, input logic [31:0] e_pc,
                               input logic [31:0] e_instr);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".instr"}, instr, e_instr);
        chk({tag, ".opcode"}, 32'(opcode), 32'(e_instr[6:0]));
    endtask

    initial begin
        rst_l = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        redir = 1'b0; redir_pc = '0; ready = 1'b0;

        tbl.push_back(v(0,1,0,32'h0,1,   0,32'h00,0,1,32'h00,32'h0));
        tbl.push_back(v(1,1,0,32'h0,1,   1,32'h00,0,0,32'h00,32'h0));
        tbl.push_back(v(1,1,1,32'h13,1,  0,32'h04,0,0,32'h00,32'h0));
        tbl.push_back(v(1,1,0,32'h0,1,   1,32'h04,1,1,32'h00,32'h13));
        tbl.push_back(v(1,1,1,32'h13,1,  0,32'h08,0,0,32'h00,32'h0));
        tbl.push_back(v(1,1,0,32'h0,1,   1,32'h08,1,1,32'h04,32'h13));
        tbl.push_back(v(1,1,1,32'h13,1,  0,32'h0c,0,0,32'h00,32'h0));
        tbl.push_back(v(1,1,0,32'h0,0,   1,32'h0c,1,1,32'h08,32'h13));
        tbl.push_back(v(1,1,1,32'h33,0,  0,32'h10,1,1,32'h08,32'h13));
        tbl.push_back(v(1,1,0,32'h0,0,   0,32'h10,1,1,32'h08,32'h13));
        tbl.push_back(v(1,1,0,32'h0,0,   0,32'h10,1,1,32'h08,32'h13));
        tbl.push_back(v(1,1,0,32'h0,1,   0,32'h10,1,1,32'h08,32'h13));
        tbl.push_back(v(1,1,0,32'h0,1,   1,32'h10,1,1,32'h0c,32'h33));
        tbl.push_back(v(1,1,1,32'h6f,1,  0,32'h14,0,0,32'h00,32'h0));
        tbl.push_back(v(1,0,0,32'h0,1,   1,32'h14,1,1,32'h10,32'h6f));

        step(0,0,0,0,0,0,0);
        step(0,0,0,0,0,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            step(tbl[i].rst, tbl[i].gnt, tbl[i].rv, tbl[i].rdata, 1'b0,
                 32'h0, tbl[i].rdy);
            expect_out(tag, tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid);
            if (tbl[i].hd) expect_head(tag, tbl[i].e_pc, tbl[i].e_instr);
        end

        for (int i = 0; i < 3; i++) begin
            step(1,0,0,0,0,0,1);
            expect_out($sformatf("stall%0d", i), 1, 32'h14, 0);
        end
        step(1,1,0,0,0,0,1);
        expect_out("stall_gnt", 1, 32'h14, 0);

        step(1,0,1,32'h13,0,0,0);
        expect_out("b1", 0, 32'h18, 0);
        step(1,1,0,0,1,32'h100,0);
        expect_out("b2", 1, 32'h18, 1);
        expect_head("b2", 32'h14, 32'h13);
        step(1,1,1,32'hdeadbeef,0,0,0);
        expect_out("b3", 0, 32'h100, 0);
        step(1,0,0,0,0,0,0);
        expect_out("b4", 1, 32'h100, 0);
        step(1,1,0,0,0,0,0);
        expect_out("b5", 1, 32'h100, 0);

        step(1,0,1,32'h13,1,32'h202,0);
        expect_out("c1", 0, 32'h104, 0);
        step(1,0,0,0,0,0,0);
        expect_out("c2", 1, 32'h200, 0);
        step(1,1,0,0,0,0,0);
        expect_out("c3", 1, 32'h200, 0);

        step(1,0,0,0,1,32'h300,0);
        expect_out("d1", 0, 32'h204, 0);
        step(1,0,1,32'h13,0,0,0);
        expect_out("d2", 0, 32'h300, 0);
        step(1,0,0,0,0,0,0);
        expect_out("d3", 1, 32'h300, 0);
        step(1,1,0,0,0,0,0);
        expect_out("d4", 1, 32'h300, 0);

        step(0,0,0,0,0,0,0);
        expect_out("e1", 0, 32'h304, 0);
        step(1,0,1,32'h13,0,0,0);
        expect_out("e2", 1, 32'h0, 0);
        step(1,0,0,0,0,0,0);
        expect_out("e3", 1, 32'h0, 0);
        step(1,1,0,0,0,0,0);
        expect_out("e4", 1, 32'h0, 0);
        step(1,0,1,32'h00500093,0,0,0);
        expect_out("e5", 0, 32'h4, 0);
        step(1,0,0,0,0,0,1);
        expect_out("e6", 1, 32'h4, 1);
        expect_head("e6", 32'h0, 32'h00500093);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
